regfile_mp: RTL

//  Parametrised successor register file for the accelerator datapath: one sequential-write,
//  one random-write, one sequential-read and one random-read port on a DEPTH x DATA_WIDTH array.

---
 rtl/regfile_mp.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: DEPTH x DATA_WIDTH register file with four ports.
//   - sequential write port (auto-incrementing, wrapping pointer)
//   - random write port (explicit address, out-of-range writes dropped)
//   - sequential read port (auto-incrementing, wrapping pointer)
//   - random read port (explicit address, out-of-range reads return 0)
// Reads are registered (one cycle latency) and report the address read.
// Each entry carries a "written" bit, cleared by reset, so an entry that
// has not been written since reset reads back as 0 even though the storage
// array itself is never reset.
// Optional build macro: REGFILE_BYPASS_EN
//   defined     -> same-cycle write-to-read forwarding (random write wins)
//   not defined -> read-first: a read sees the contents before the write
module regfile_mp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seq_ptr_clr,
    input  logic                  seq_we,
    input  logic [DATA_WIDTH-1:0] seq_w_data,
    output logic [ADDR_WIDTH-1:0] out_seq_w_addr,
    input  logic                  ran_we,
    input  logic [ADDR_WIDTH-1:0] ran_w_addr,
    input  logic [DATA_WIDTH-1:0] ran_w_data,
    input  logic                  seq_re,
    output logic [DATA_WIDTH-1:0] seq_r_data,
    output logic                  seq_r_valid,
    output logic [ADDR_WIDTH-1:0] out_seq_r_addr,
    input  logic                  ran_re,
    input  logic [ADDR_WIDTH-1:0] ran_r_addr,
    output logic [DATA_WIDTH-1:0] ran_r_data,
    output logic                  ran_r_valid,
    output logic [ADDR_WIDTH-1:0] out_ran_r_addr,
    output logic                  addr_err
);

    // Index width needed to address DEPTH entries; addresses are sliced to
    // this width only after they have been range-checked.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      written;

    logic [ADDR_WIDTH-1:0] seq_w_ptr;
    logic [ADDR_WIDTH-1:0] seq_r_ptr;

    logic [IDX_W-1:0]      seq_w_idx;
    logic [IDX_W-1:0]      seq_r_idx;
    logic [IDX_W-1:0]      ran_w_idx;
    logic [IDX_W-1:0]      ran_r_idx;

    logic                  ran_w_in_range;
    logic                  ran_r_in_range;
    logic                  ran_w_ok;

    logic [DATA_WIDTH-1:0] seq_rd_word;
    logic [DATA_WIDTH-1:0] ran_rd_word;

    // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
        return (ptr == LAST_ADDR) ? '0 : ptr + ADDR_WIDTH'(1);
    endfunction

    // Address decode and range checks for the random ports.
    always_comb begin
        seq_w_idx      = seq_w_ptr[IDX_W-1:0];
        seq_r_idx      = seq_r_ptr[IDX_W-1:0];
        ran_w_idx      = ran_w_addr[IDX_W-1:0];
        ran_r_idx      = ran_r_addr[IDX_W-1:0];
        ran_w_in_range = ({1'b0, ran_w_addr} < DEPTH_EXT);
        ran_r_in_range = ({1'b0, ran_r_addr} < DEPTH_EXT);
        ran_w_ok       = ran_we && ran_w_in_range;
    end

    // Read-word selection: stored value (0 if never written), optionally
    // overridden by a same-cycle write to the same entry.
    always_comb begin
        seq_rd_word = written[seq_r_idx] ? mem[seq_r_idx] : '0;
        ran_rd_word = '0;
        if (ran_r_in_range) begin
            ran_rd_word = written[ran_r_idx] ? mem[ran_r_idx] : '0;
        end
`ifdef REGFILE_BYPASS_EN
        // Random write is applied last so it wins over the sequential write.
        if (seq_we && (seq_w_ptr == seq_r_ptr)) begin
            seq_rd_word = seq_w_data;
        end
        if (ran_w_ok && (ran_w_addr == seq_r_ptr)) begin
            seq_rd_word = ran_w_data;
        end
        if (ran_r_in_range && seq_we && (seq_w_ptr == ran_r_addr)) begin
            ran_rd_word = seq_w_data;
        end
        if (ran_r_in_range && ran_w_ok && (ran_w_addr == ran_r_addr)) begin
            ran_rd_word = ran_w_data;
        end
`endif
    end

    // Storage array: no reset; random write is last so it wins a collision.
    always_ff @(posedge clk) begin
        if (seq_we) begin
            mem[seq_w_idx] <= seq_w_data;
        end
        if (ran_w_ok) begin
            mem[ran_w_idx] <= ran_w_data;
        end
    end

    // Per-entry written flags, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written <= '0;
        end else begin
            if (seq_we) begin
                written[seq_w_idx] <= 1'b1;
            end
            if (ran_w_ok) begin
                written[ran_w_idx] <= 1'b1;
            end
        end
    end

    // Sequential pointers: clear has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_w_ptr <= '0;
            seq_r_ptr <= '0;
        end else if (seq_ptr_clr) begin
            seq_w_ptr <= '0;
            seq_r_ptr <= '0;
        end else begin
            if (seq_we) begin
                seq_w_ptr <= next_ptr(seq_w_ptr);
            end
            if (seq_re) begin
                seq_r_ptr <= next_ptr(seq_r_ptr);
            end
        end
    end

    assign out_seq_w_addr = seq_w_ptr;

    // Sequential read port: registered data/address, valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_r_data     <= '0;
            seq_r_valid    <= 1'b0;
            out_seq_r_addr <= '0;
        end else begin
            seq_r_valid <= seq_re;
            if (seq_re) begin
                seq_r_data     <= seq_rd_word;
                out_seq_r_addr <= seq_r_ptr;
            end
        end
    end

    // Random read port: out-of-range reads still complete, returning 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ran_r_data     <= '0;
            ran_r_valid    <= 1'b0;
            out_ran_r_addr <= '0;
        end else begin
            ran_r_valid <= ran_re;
            if (ran_re) begin
                ran_r_data     <= ran_rd_word;
                out_ran_r_addr <= ran_r_addr;
            end
        end
    end

    // Address error: one-cycle pulse for any out-of-range random access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else begin
            addr_err <= (ran_we && !ran_w_in_range) || (ran_re && !ran_r_in_range);
        end
    end

endmodule
